// File: rtl/axis_pkg.sv
// ----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI4-Stream sink blocks.
//   - state_t         : consumer FSM state encoding (IDLE/RECV/HOLD)
//   - AXIS_DATA_WIDTH : default stream data width
// ----------------------------------------------------------------------------
package axis_pkg;

    localparam int AXIS_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/ready_pattern_gen.sv
// ----------------------------------------------------------------------------
// ready_pattern_gen
// Free-running phase counter 0..READY_PERIOD-1 that produces the value the
// periodic ready pattern will have in the next cycle, so a sink can register
// its ready output without a combinational path.
//
// Parameters:
//   READY_PERIOD : pattern length in cycles (>= 1)
//   READY_ON     : cycles per period with the pattern high (0..READY_PERIOD)
// Ports:
//   i_clk          : clock
//   i_rst_n        : asynchronous active-low reset (phase returns to 0)
//   o_pattern_next : (phase_next < READY_ON)
// ----------------------------------------------------------------------------
module ready_pattern_gen #(
    parameter int READY_PERIOD = 4,
    parameter int READY_ON     = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_pattern_next
);

    localparam int            PW   = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
    localparam logic [PW-1:0] LAST = PW'(READY_PERIOD - 1);

    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_next;

    // The counter runs unconditionally; enable and FSM state only gate the
    // consumer's ready, never the pattern itself.
    assign w_phase_next   = (r_phase == LAST) ? '0 : r_phase + PW'(1);
    assign o_pattern_next = (int'(w_phase_next) < READY_ON);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
        end else begin
            r_phase <= w_phase_next;
        end
    end

endmodule

// File: rtl/axis_consumer.sv
// ----------------------------------------------------------------------------
// axis_consumer
// AXI4-Stream sink: applies a periodic backpressure pattern on s_tready,
// accumulates a per-packet byte sum and beat count, and publishes both for
// one cycle after each packet ends (tlast or forced at MAX_LEN beats).
//
// Build option:
//   AXIS_CONSUMER_SEQ_CHECK_EN : when defined, every non-first beat of a
//   packet must equal previous tdata + 1; violations set sticky seq_err.
//   When undefined, no checker is built and seq_err is 0.
//
// Handshake: a beat transfers on a rising edge where s_tvalid and s_tready
// are both 1; nothing else qualifies it. s_tready is a register and never
// looks at s_tvalid, so it may drop while a beat is pending and the
// producer must hold that beat.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   enable              : forces s_tready low when 0
//   s_tdata/tvalid/tlast: stream input
//   s_tready            : stream ready (registered)
//   sum_out, len_out    : checksum and beat count of last completed packet
//   sum_valid           : one-cycle pulse when sum_out/len_out update
//   pkt_count           : completed packets, wrapping
//   len_err             : sticky, packet hit MAX_LEN beats without tlast
//   seq_err             : sticky sequence error (build option above)
//   dbg_state           : current FSM state (axis_pkg::state_t encoding)
// ----------------------------------------------------------------------------
module axis_consumer
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH   = AXIS_DATA_WIDTH,
    parameter int SUM_WIDTH    = 16,
    parameter int MAX_LEN      = 64,
    parameter int READY_PERIOD = 4,
    parameter int READY_ON     = 3,
    parameter int CNT_WIDTH    = 16,
    localparam int LEN_WIDTH   = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [SUM_WIDTH-1:0]  sum_out,
    output logic [LEN_WIDTH-1:0]  len_out,
    output logic                  sum_valid,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  len_err,
    output logic                  seq_err,
    output logic [1:0]            dbg_state
);

    state_t                 r_state;
    logic                   r_tready;
    logic [SUM_WIDTH-1:0]   r_acc;
    logic [LEN_WIDTH-1:0]   r_cnt;
    logic [SUM_WIDTH-1:0]   r_sum;
    logic [LEN_WIDTH-1:0]   r_len;
    logic                   r_sum_valid;
    logic [CNT_WIDTH-1:0]   r_pkt_count;
    logic                   r_len_err;

    logic                   w_pattern_next;
    logic                   w_xfer;
    logic [LEN_WIDTH-1:0]   w_cnt_inc;
    logic                   w_pkt_end;

    ready_pattern_gen #(
        .READY_PERIOD (READY_PERIOD),
        .READY_ON     (READY_ON)
    ) u_ready_pattern_gen (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .o_pattern_next (w_pattern_next)
    );

    assign w_xfer    = s_tvalid & r_tready;
    assign w_cnt_inc = r_cnt + LEN_WIDTH'(1);

    // A transfer that closes the packet is exactly the case where the next
    // state is HOLD; ready for the HOLD cycle is computed from this.
    always_comb begin
        w_pkt_end = 1'b0;
        if (w_xfer) begin
            if (r_state == IDLE) begin
                w_pkt_end = s_tlast | (MAX_LEN == 1);
            end else if (r_state == RECV) begin
                w_pkt_end = s_tlast | (w_cnt_inc == LEN_WIDTH'(MAX_LEN));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tready    <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_len       <= '0;
            r_sum_valid <= 1'b0;
            r_pkt_count <= '0;
            r_len_err   <= 1'b0;
        end else begin
            r_tready    <= enable & w_pattern_next & ~w_pkt_end;
            r_sum_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_acc   <= SUM_WIDTH'(s_tdata);
                        r_cnt   <= LEN_WIDTH'(1);
                        r_state <= w_pkt_end ? HOLD : RECV;
                    end
                end
                RECV: begin
                    if (w_xfer) begin
                        r_acc <= r_acc + SUM_WIDTH'(s_tdata);
                        r_cnt <= w_cnt_inc;
                        if (w_pkt_end) begin
                            r_state <= HOLD;
                            // Closing on the length limit, not on tlast.
                            if (!s_tlast) begin
                                r_len_err <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    r_sum       <= r_acc;
                    r_len       <= r_cnt;
                    r_sum_valid <= 1'b1;
                    r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef AXIS_CONSUMER_SEQ_CHECK_EN
    logic [DATA_WIDTH-1:0] r_prev_data;
    logic                  r_seq_err;

    // Only beats taken in RECV are checked: the first beat of a packet is
    // always taken in IDLE and carries no constraint.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_data <= '0;
            r_seq_err   <= 1'b0;
        end else if (w_xfer) begin
            r_prev_data <= s_tdata;
            if ((r_state == RECV) && (s_tdata != DATA_WIDTH'(r_prev_data + 1'b1))) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign seq_err = r_seq_err;
`else
    assign seq_err = 1'b0;
`endif

    assign s_tready  = r_tready;
    assign sum_out   = r_sum;
    assign len_out   = r_len;
    assign sum_valid = r_sum_valid;
    assign pkt_count = r_pkt_count;
    assign len_err   = r_len_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_axis_consumer.sv
// ----------------------------------------------------------------------------
// tb_axis_consumer
// Two consumers share clock/reset: channel 0 with MAX_LEN=4 (forced
// termination) and channel 1 with MAX_LEN=512 (long packets, checksum wrap).
// A behavioural model tracks each channel as "running sum/length of the open
// packet plus one result waiting to be published" and is compared with the
// DUT outputs on every falling edge.
// ----------------------------------------------------------------------------
module tb_axis_consumer;

    localparam int P   = 4;
    localparam int ON  = 3;
    localparam int ML0 = 4;
    localparam int ML1 = 512;
    localparam int LW0 = $clog2(ML0 + 1);
    localparam int LW1 = $clog2(ML1 + 1);
`ifdef AXIS_CONSUMER_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic           en  [2];
    logic           tv  [2];
    logic           tl  [2];
    logic [7:0]     td  [2];
    logic           rdy [2];
    logic [15:0]    sum [2];
    logic           sv  [2];
    logic [15:0]    pc  [2];
    logic           le  [2];
    logic           se  [2];
    logic [1:0]     dbg [2];
    logic [LW0-1:0] len0;
    logic [LW1-1:0] len1;
    logic [15:0]    len_a [2];

    assign len_a[0] = 16'(len0);
    assign len_a[1] = 16'(len1);

    axis_consumer #(.MAX_LEN(ML0), .READY_PERIOD(P), .READY_ON(ON)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]),
        .s_tdata(td[0]), .s_tvalid(tv[0]), .s_tlast(tl[0]), .s_tready(rdy[0]),
        .sum_out(sum[0]), .len_out(len0), .sum_valid(sv[0]), .pkt_count(pc[0]),
        .len_err(le[0]), .seq_err(se[0]), .dbg_state(dbg[0])
    );

    axis_consumer #(.MAX_LEN(ML1), .READY_PERIOD(P), .READY_ON(ON)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]),
        .s_tdata(td[1]), .s_tvalid(tv[1]), .s_tlast(tl[1]), .s_tready(rdy[1]),
        .sum_out(sum[1]), .len_out(len1), .sum_valid(sv[1]), .pkt_count(pc[1]),
        .len_err(le[1]), .seq_err(se[1]), .dbg_state(dbg[1])
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d t=%0t: got %0h expected %0h", name, ch, $time, act, exp);
        end
    endtask

    function automatic int max_len(input int ch);
        return (ch == 0) ? ML0 : ML1;
    endfunction

    // Model state
    int m_phase;
    bit m_rdy   [2];
    bit m_pend  [2];
    int m_pend_sum [2];
    int m_pend_len [2];
    int m_run_sum  [2];
    int m_run_len  [2];
    int m_prev  [2];
    int m_sum   [2];
    int m_len   [2];
    bit m_sv    [2];
    int m_pc    [2];
    bit m_le    [2];
    bit m_se    [2];

    // Published results captured from the DUT for literal checks
    int got_sum [2][64];
    int got_len [2][64];
    int got_n   [2];

    initial begin
        got_n[0] = 0;
        got_n[1] = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            for (int ch = 0; ch < 2; ch++) begin
                m_rdy[ch] = 0; m_pend[ch] = 0; m_pend_sum[ch] = 0; m_pend_len[ch] = 0;
                m_run_sum[ch] = 0; m_run_len[ch] = 0; m_prev[ch] = 0;
                m_sum[ch] = 0; m_len[ch] = 0; m_sv[ch] = 0; m_pc[ch] = 0;
                m_le[ch] = 0; m_se[ch] = 0;
                chk("rst_tready", ch, rdy[ch], 0);
                chk("rst_sum_valid", ch, sv[ch], 0);
                chk("rst_sum_out", ch, sum[ch], 0);
                chk("rst_len_out", ch, len_a[ch], 0);
                chk("rst_pkt_count", ch, pc[ch], 0);
                chk("rst_len_err", ch, le[ch], 0);
                chk("rst_seq_err", ch, se[ch], 0);
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                chk("tready", ch, rdy[ch], m_rdy[ch]);
                chk("sum_valid", ch, sv[ch], m_sv[ch]);
                chk("sum_out", ch, sum[ch], m_sum[ch]);
                chk("len_out", ch, len_a[ch], m_len[ch]);
                chk("pkt_count", ch, pc[ch], m_pc[ch]);
                chk("len_err", ch, le[ch], m_le[ch]);
                chk("seq_err", ch, se[ch], m_se[ch]);
                if (sv[ch] === 1'b1 && got_n[ch] < 64) begin
                    got_sum[ch][got_n[ch]] = int'(sum[ch]);
                    got_len[ch][got_n[ch]] = int'(len_a[ch]);
                    got_n[ch]++;
                end
            end
            // Advance to the state after the coming rising edge; inputs are
            // stable from here until that edge.
            m_phase = (m_phase + 1) % P;
            for (int ch = 0; ch < 2; ch++) begin
                bit hs;
                bit next_pend;
                hs = tv[ch] && m_rdy[ch];
                next_pend = 0;
                m_sv[ch] = 0;
                if (m_pend[ch]) begin
                    m_sum[ch] = m_pend_sum[ch];
                    m_len[ch] = m_pend_len[ch];
                    m_sv[ch]  = 1;
                    m_pc[ch]  = (m_pc[ch] + 1) % 65536;
                end
                if (hs) begin
                    if (SEQ_EN && m_run_len[ch] > 0 && int'(td[ch]) != (m_prev[ch] + 1) % 256)
                        m_se[ch] = 1;
                    m_prev[ch]    = int'(td[ch]);
                    m_run_sum[ch] = (m_run_sum[ch] + int'(td[ch])) % 65536;
                    m_run_len[ch] = m_run_len[ch] + 1;
                    if (tl[ch] || m_run_len[ch] == max_len(ch)) begin
                        if (!tl[ch]) m_le[ch] = 1;
                        m_pend_sum[ch] = m_run_sum[ch];
                        m_pend_len[ch] = m_run_len[ch];
                        m_run_sum[ch]  = 0;
                        m_run_len[ch]  = 0;
                        next_pend      = 1;
                    end
                end
                m_pend[ch] = next_pend;
                m_rdy[ch]  = en[ch] && (m_phase < ON) && !next_pend;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until a handshake edge has passed.
    task automatic send_beat(input int ch, input logic [7:0] d, input logic last);
        int  n;
        bit  done;
        tv[ch] = 1'b1; td[ch] = d; tl[ch] = last;
        done = 0; n = 0;
        while (!done && n <= 200) begin
            @(negedge clk);
            done = rdy[ch];
            tick();
            n++;
        end
        chk("handshake_timeout", ch, done, 1);
        tv[ch] = 1'b0; tl[ch] = 1'b0;
    endtask

    // mode 0: constant d0, mode 1: incrementing from d0, mode 2: random
    task automatic send_pkt(input int ch, input int n, input int mode, input logic [7:0] d0,
                            input bit last, input bit gaps);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            if (mode == 0)      d = d0;
            else if (mode == 1) d = d0 + 8'(i);
            else                d = 8'($urandom_range(0, 255));
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            send_beat(ch, d, last && (i == n - 1));
        end
    endtask

    task automatic wait_result(input int ch, input int idx);
        int n;
        n = 0;
        while (got_n[ch] <= idx && n < 20) begin
            tick();
            n++;
        end
        chk("result_arrival", ch, got_n[ch] > idx, 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] exp_pat;
        for (int ch = 0; ch < 2; ch++) begin
            en[ch] = 1'b1; tv[ch] = 1'b0; tl[ch] = 1'b0; td[ch] = 8'h00;
        end

        // Reset then idle
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_pat = 8'b0111_0110;  // bit i = ready in cycle i after release
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("ready_pattern", 0, rdy[0], exp_pat[i]);
        end
        tick();

        // Single packet 01..04
        send_pkt(0, 4, 1, 8'h01, 1, 0);
        wait_result(0, 0);
        chk("single_sum", 0, got_sum[0][0], 32'h000A);
        chk("single_len", 0, got_len[0][0], 4);
        chk("single_pkt_count", 0, pc[0], 1);
        chk("single_len_err", 0, le[0], 0);

        // Sequence check 05,06,08
        send_beat(0, 8'h05, 1'b0);
        send_beat(0, 8'h06, 1'b0);
        chk("seq_before_bad", 0, se[0], 0);
        send_beat(0, 8'h08, 1'b1);
        chk("seq_after_bad", 0, se[0], SEQ_EN);
        wait_result(0, 1);
        chk("seq_pkt_sum", 0, got_sum[0][1], 32'h0013);
        chk("seq_pkt_len", 0, got_len[0][1], 3);
        repeat (3) tick();
        chk("seq_sticky", 0, se[0], SEQ_EN);

        // Overlength: 6 beats of 0x10 with MAX_LEN = 4
        send_pkt(0, 6, 0, 8'h10, 1, 0);
        wait_result(0, 3);
        chk("over_sum0", 0, got_sum[0][2], 32'h0040);
        chk("over_len0", 0, got_len[0][2], 4);
        chk("over_sum1", 0, got_sum[0][3], 32'h0020);
        chk("over_len1", 0, got_len[0][3], 2);
        chk("over_len_err", 0, le[0], 1);

        // Backpressure hold: continuous valid across ready-low phases
        send_pkt(1, 7, 1, 8'h01, 1, 0);
        wait_result(1, 0);
        chk("bp_sum", 1, got_sum[1][0], 32'h001C);
        chk("bp_len", 1, got_len[1][0], 7);

        // Wrap and enable: 300 x 0xFF, enable dropped mid-packet with a beat pending
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                en[1] = 1'b0;
                tick();
                @(negedge clk);
                chk("enable_drop_ready", 1, rdy[1], 0);
                tick();
                tv[1] = 1'b1; td[1] = 8'hFF; tl[1] = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("enable_low_ready", 1, rdy[1], 0);
                    tick();
                end
                en[1] = 1'b1;
            end
            send_beat(1, 8'hFF, i == 299);
        end
        wait_result(1, 1);
        chk("wrap_sum", 1, got_sum[1][1], 32'h2AD4);
        chk("wrap_len", 1, got_len[1][1], 300);

        // Randomized packets on both channels
        for (int p = 0; p < 16; p++) begin
            int ch;
            ch = p % 2;
            send_pkt(ch, $urandom_range(1, 10), $urandom_range(0, 2),
                     8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, 1);
        end
        repeat (6) tick();

        // Reset mid-packet discards the partial packet
        send_beat(0, 8'h40, 1'b0);
        send_beat(1, 8'h40, 1'b0);
        #2 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        begin
            int base;
            base = got_n[0];
            send_pkt(0, 2, 1, 8'h03, 1, 0);
            wait_result(0, base);
            chk("post_reset_sum", 0, got_sum[0][base], 32'h0007);
            chk("post_reset_len", 0, got_len[0][base], 2);
            chk("post_reset_pkt_count", 0, pc[0], 1);
        end
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_consumer.md
Name: axis_consumer

Overview:
- AXI4-Stream sink that sits directly downstream of the stream producer and terminates the stream inside `top`.
- Drives `s_tready` with a programmable periodic backpressure pattern, gated by an external enable.
- Accumulates a per-packet byte sum and beat count, and publishes both for one cycle after each `tlast`.
- Keeps running packet and error statistics for the testbench and for the LEDs.

Parameters:
- DATA_WIDTH, 8, width of `s_tdata`.
- SUM_WIDTH, 16, checksum accumulator width; wraps modulo 2^SUM_WIDTH.
- MAX_LEN, 64, maximum beats per packet before a forced termination.
- READY_PERIOD, 4, length in cycles of the backpressure pattern; minimum 1.
- READY_ON, 3, number of cycles per period with ready asserted; range 0..READY_PERIOD.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, reset. Asynchronous assert, active low.
- enable, in, 1, consumer enable. Ready is forced low while this is 0.
- s_tdata, in, DATA_WIDTH, stream data.
- s_tvalid, in, 1, stream valid.
- s_tlast, in, 1, last beat of the packet.
- s_tready, out, 1, stream ready.
- sum_out, out, SUM_WIDTH, checksum of the last completed packet.
- len_out, out, $clog2(MAX_LEN+1), beat count of the last completed packet.
- sum_valid, out, 1, one-cycle pulse when `sum_out` and `len_out` update.
- pkt_count, out, CNT_WIDTH, number of completed packets; wraps.
- len_err, out, 1, sticky flag: a packet reached MAX_LEN beats without `tlast`.
- seq_err, out, 1, sticky sequence error flag (see Optional Feature).

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Phase counter 0.
- Reset mid-packet discards the partial sum and count; there is no output pulse.
- Transfer: a beat transfers on a rising edge where `s_tvalid` and `s_tready` are both 1. No other signal qualifies a transfer.
- Phase counter:
  - Free-running 0..READY_PERIOD-1; wraps to 0.
  - Runs regardless of `enable` or FSM state.
  - `pattern = (phase < READY_ON)`.
- `s_tready` is registered. Its next value is `enable & pattern_next & (next_state != HOLD)`.
- `s_tready` never depends combinationally on `s_tvalid`.
- Ready may deassert while valid is pending; the producer holds its beat.
- FSM states:
  - IDLE:
    - On transfer, load `acc = tdata` (zero-extended) and `cnt = 1`.
    - If `tlast` is set, or MAX_LEN == 1, go to HOLD; otherwise go to RECV.
  - RECV:
    - On transfer, `acc += tdata` (mod 2^SUM_WIDTH) and `cnt += 1`.
    - Go to HOLD if `tlast` is set, or if the new `cnt` equals MAX_LEN. In the MAX_LEN case without `tlast`, set `len_err`.
  - HOLD:
    - Lasts exactly 1 cycle, with ready low.
    - Copy `acc` to `sum_out` and `cnt` to `len_out`, pulse `sum_valid`, and increment `pkt_count`.
    - Return to IDLE.
- The result of a packet is visible 2 cycles after its `tlast` handshake edge: HOLD register, then output register. `sum_valid` is high for exactly 1 cycle.
- A forced termination at MAX_LEN treats the following beats as a new packet.
- `len_err` and `seq_err` clear only on reset.
- Degenerate patterns:
  - READY_ON = 0: ready is never asserted.
  - READY_ON = READY_PERIOD: ready is continuous, except during HOLD and while `enable` = 0.
- `enable` falling mid-packet: ready drops on the next cycle. Packet state is retained and resumes when `enable` returns.

Optional Feature:
- Macro: AXIS_CONSUMER_SEQ_CHECK_EN.
- Defined:
  - Every beat after the first of a packet must equal the previous `tdata` + 1, modulo 2^DATA_WIDTH.
  - A mismatch sets `seq_err` one cycle after the offending handshake.
  - The first beat of a packet has no constraint.
- Undefined: no checker logic is built, and `seq_err` is tied to 0.

Decomposition:
- Shared package `axis_pkg`:
  - FSM state encoding: IDLE = 2'd0, RECV = 2'd1, HOLD = 2'd2.
  - Default DATA_WIDTH.
- Sub-module `ready_pattern_gen`:
  - Parameters READY_PERIOD and READY_ON.
  - Produces `pattern_next` from the phase counter.
  - Reused by future stream sinks.
- The accumulator, FSM and checker stay in `axis_consumer`.

Test Plan:
- Reset then idle:
  - Stimulus: `rst_n` low for 5 cycles, `s_tvalid` = 0.
  - Response: all outputs 0. After release with `enable` = 1, `s_tready` follows 1,1,1,0 repeating.
- Single packet:
  - Stimulus: data 0x01,0x02,0x03,0x04 with `tlast` on 0x04, defaults.
  - Response: `sum_out` = 0x000A, `len_out` = 4, one `sum_valid` pulse, `pkt_count` = 1, `s_tready` low for the HOLD cycle.
- Backpressure hold:
  - Stimulus: `s_tvalid` held high through a ready-low phase.
  - Response: the beat is counted exactly once; `len_out` matches the number of handshakes.
- Overlength:
  - Stimulus: MAX_LEN = 4; 6 beats of 0x10, `tlast` on beat 6.
  - Response: first result sum 0x0040 with len 4, `len_err` = 1; second result sum 0x0020 with len 2.
- Wrap and enable:
  - Stimulus: 300 beats of 0xFF with `tlast` on the last; MAX_LEN = 512.
  - Response: `sum_out` = 0x2AD4 (300*255 mod 2^16 = 76500 − 65536).
  - Additionally, dropping `enable` mid-packet forces ready low within 1 cycle, and the sum is intact after resuming.
- Sequence check (macro defined):
  - Stimulus: 0x05,0x06,0x08.
  - Response: `seq_err` rises one cycle after the 0x08 handshake and stays high.
  - Without the macro, `seq_err` stays 0.
